pe_dot_ctrl: RTL and testbench
==============================

# pe_dot_ctrl

Sequencing controller for the 32-lane int16 parallel multiplier array. It accepts a dot-product job (vector length in 32-lane beats, plus a bias) and streams neuron/weight beats through an externally instantiated `pe_mult` using a valid/ready handshake. It reduces each beat's 32 products, accumulates the partial sums into a partial-sum register seeded with the bias, and presents one 32-bit result per job on an output handshake. The block sits between the neuron/weight buffers and the activation/output stage of the PE.

## Interface
- `LEN_W`, 16: width of `vec_len`; max job length is 2^LEN_W−1 beats.
- `ACC_W`, 56: accumulator width. Must be ≥ 38 + LEN_W to be overflow-free.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `vec_len`  in  LEN_W  beats in job; sampled with `start`.
- `bias`  in  32  signed bias; sampled with `start`.
- `busy`  out  1  high in any state except IDLE.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `neuron`  in  512  32 × int16 neuron lanes; lane i = bits [16i+15:16i].
- `weight`  in  512  32 × int16 weight lanes, same packing.
- `mult_neuron`  out  512  to `pe_mult.neuron`; combinational pass-through of `neuron`.
- `mult_weight`  out  512  to `pe_mult.weight`; combinational pass-through of `weight`.
- `mult_result`  in  1024  from `pe_mult`; 32 × signed 32-bit products.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  32  signed result.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE, `start`=1:
  - load `acc` ← sign-extended `bias`; load `remain` ← `vec_len`.
  - If `vec_len`=0, go to OUT; otherwise go to RUN.
- RUN:
  - `in_ready` = 1.
  - On each handshake, `psum` ← signed sum of the 32 products (38-bit, sign-extended per lane), `psum_vld` ← 1, and `remain` decrements.
  - The handshake that takes `remain` from 1 to 0 moves the FSM to DRAIN.
  - A cycle without a handshake leaves `psum_vld` ← 0.
- Accumulate stage, any state: if `psum_vld`, `acc` ← `acc` + sign-extended `psum`.
- DRAIN: `in_ready` = 0. The FSM stays one cycle so the last `psum` is added, then goes to OUT.
- OUT:
  - `out_valid` = 1 and `out_data` = result of `acc` (see Configuration).
  - `out_data` is held stable until `out_ready`.
  - On the output handshake, go to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- `in_ready` is 0 in IDLE, DRAIN and OUT. `in_valid` in those states has no effect.
- Reset, including mid-job: all state clears and in-flight beats and partial sums are discarded.
- Reset values:
  - `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0.
  - FSM=IDLE, `acc`=0, `psum_vld`=0, `remain`=0.

## Timing
- `in_ready` rises the cycle after the `start` cycle.
- Back-to-back beats are accepted at 1 beat/cycle with no bubbles.
- Last beat handshake in cycle T: `out_valid` is high from cycle T+2.
- `vec_len`=0: `out_valid` is high in cycle S+1, where S is the `start` cycle.
- Output handshake in cycle U:
  - `busy` and `out_valid` are 0 in U+1.
  - A new `start` is accepted in U+1.
- Minimum job period: `vec_len` + 3 cycles.
- The combinational path is `neuron`/`weight` → `pe_mult` → 32-input adder tree → `psum` register. `pe_mult` has no registers.

## Configuration
- `PE_SAT_EN` defined: `out_data` = `acc` saturated to the signed 32-bit range.
  - `acc` > 2147483647 gives 0x7FFFFFFF.
  - `acc` < −2147483648 gives 0x80000000.
- `PE_SAT_EN` undefined: `out_data` = `acc[31:0]` (wrap-around truncation).

## Test plan
- Reset mid-job: raise `rst` during RUN with 3 beats accepted of `vec_len`=8.
  - All outputs go to reset values.
  - A new job with `vec_len`=1 and `bias`=0, then a beat with all lanes 1×1, gives `out_data`=32.
- Basic job: `vec_len`=2, `bias`=10; beat 1 all lanes 2×3, beat 2 all lanes (−1)×4.
  - `out_data` = 10 + 192 − 128 = 74.
  - `out_valid` rises 2 cycles after the second handshake.
- Zero length and start while busy:
  - `vec_len`=0, `bias`=−5 gives `out_data`=−5 one cycle after `start`.
  - A `start` pulsed during OUT is ignored.
- Backpressure on both sides: `in_valid` toggles randomly and `out_ready` is held low for 5 cycles.
  - The result matches the golden model.
  - `out_data` stays stable while `out_valid` is high.
- Saturation: `vec_len`=3, all lanes 32767×32767.
  - With `PE_SAT_EN` defined: `out_data`=0x7FFFFFFF.
  - Without it: `out_data` = low 32 bits of 3·32·1073676289.
- Negative extreme: all lanes −32768×32767, `vec_len`=1.
  - `out_data` = −34358689792 saturated to 0x80000000 with `PE_SAT_EN` defined, or its low 32 bits without it.

Source files
------------

// File: rtl/pe_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_dot_ctrl
// Brief    : Dot-product sequencer for the 32-lane int16 multiplier array.
//            Define PE_SAT_EN to saturate the result to signed 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module pe_dot_ctrl #(
   parameter int LEN_W = 16,
   parameter int ACC_W = 56
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic [31:0]       bias,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [511:0]      neuron,
   input  logic [511:0]      weight,
   output logic [511:0]      mult_neuron,
   output logic [511:0]      mult_weight,
   input  logic [1023:0]     mult_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data
);

   localparam int               c_PSUM_W = 38;
   localparam logic [LEN_W-1:0] c_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LEN_W-1:0]    r_remain;
   logic [ACC_W-1:0]    r_acc;
   logic [c_PSUM_W-1:0] r_psum;
   logic                r_psum_vld;
   logic [c_PSUM_W-1:0] w_psum;
   logic                w_beat_hs;
   logic                w_load;
   logic [31:0]         w_result;

   assign mult_neuron = neuron;
   assign mult_weight = weight;

   assign w_beat_hs = in_valid && in_ready;
   assign w_load    = (r_state == ST_IDLE) && start;

   // 32-input reduction of the sign-extended lane products
   always_comb begin
      w_psum = '0;
      for (int i = 0; i < 32; i++) begin
         w_psum = w_psum + {{(c_PSUM_W-32){mult_result[32*i+31]}}, mult_result[32*i +: 32]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (vec_len == '0) begin
                  w_state_nxt = ST_OUT;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            in_ready = 1'b1;
            if (in_valid && (r_remain == c_ONE)) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_state_nxt = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_remain   <= '0;
         r_acc      <= '0;
         r_psum     <= '0;
         r_psum_vld <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_psum_vld <= w_beat_hs;
         if (w_beat_hs) begin
            r_psum   <= w_psum;
            r_remain <= r_remain - c_ONE;
         end
         // psum_vld is never set in IDLE, so the bias load cannot collide with an add
         if (w_load) begin
            r_acc    <= {{(ACC_W-32){bias[31]}}, bias};
            r_remain <= vec_len;
         end else if (r_psum_vld) begin
            r_acc <= r_acc + {{(ACC_W-c_PSUM_W){r_psum[c_PSUM_W-1]}}, r_psum};
         end
      end
   end

`ifdef PE_SAT_EN
   always_comb begin
      w_result = r_acc[31:0];
      if (r_acc[ACC_W-1:31] != {(ACC_W-31){r_acc[ACC_W-1]}}) begin
         w_result = r_acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end
`else
   assign w_result = r_acc[31:0];
`endif

   assign out_data = (r_state == ST_OUT) ? w_result : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_dot_ctrl
// Brief    : Scoreboard bench for pe_dot_ctrl with a behavioural pe_mult.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_dot_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [15:0]   vec_len;
   logic [31:0]   bias;
   logic          busy;
   logic          in_valid;
   logic          in_ready;
   logic [511:0]  neuron;
   logic [511:0]  weight;
   logic [511:0]  mult_neuron;
   logic [511:0]  mult_weight;
   logic [1023:0] mult_result;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [31:0]   sb_q[$];
   logic          prev_valid = 1'b0;
   logic [31:0]   prev_data  = '0;

   always #5 clk = ~clk;

   pe_dot_ctrl #(.LEN_W(16), .ACC_W(56)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .vec_len     (vec_len),
      .bias        (bias),
      .busy        (busy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .neuron      (neuron),
      .weight      (weight),
      .mult_neuron (mult_neuron),
      .mult_weight (mult_weight),
      .mult_result (mult_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data)
   );

   // Purely combinational multiplier array
   for (genvar g = 0; g < 32; g++) begin : g_mult
      logic signed [31:0] a;
      logic signed [31:0] b;
      assign a = 32'(signed'(mult_neuron[16*g +: 16]));
      assign b = 32'(signed'(mult_weight[16*g +: 16]));
      assign mult_result[32*g +: 32] = a * b;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic longint beat_sum(input logic [511:0] n, input logic [511:0] w);
      longint s = 0;
      for (int i = 0; i < 32; i++) begin
         logic signed [15:0] a;
         logic signed [15:0] b;
         a = n[16*i +: 16];
         b = w[16*i +: 16];
         s += longint'(a) * longint'(b);
      end
      return s;
   endfunction

   function automatic logic [31:0] sat32(input longint v);
      logic [63:0] u;
      u = v;
`ifdef PE_SAT_EN
      if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
      return u[31:0];
   endfunction

   // Output monitor: pops the scoreboard on every result handshake
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && prev_valid) chk("hold_stable", out_data, prev_data);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected", 1, 0);
            end else begin
               chk("sb_result", out_data, sb_q.pop_front());
            end
         end
         prev_valid = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic set_beat(input bit dir, input int dn, input int dw);
      logic [15:0] n16;
      logic [15:0] w16;
      if (dir) begin
         n16    = 16'(dn);
         w16    = 16'(dw);
         neuron = {32{n16}};
         weight = {32{w16}};
      end else begin
         for (int k = 0; k < 16; k++) begin
            neuron[32*k +: 32] = $urandom;
            weight[32*k +: 32] = $urandom;
         end
      end
   endtask

   // Entered at posedge+1 with the DUT idle; returns at posedge+1 after the result handshake
   task automatic run_job(input int len, input int b, input int vprob, input int hold,
                          input bit dir, input int dn0, input int dw0, input int dn1, input int dw1,
                          input bit has_c, input logic [31:0] c_exp, input bit pulse);
      longint sum;
      int     got;
      int     guard;
      bit     hs;
      logic [31:0] lenv;
      sum  = longint'(b);
      lenv = len;
      chk("idle_busy", busy, 0);
      start   = 1'b1;
      vec_len = lenv[15:0];
      bias    = b;
      @(posedge clk); #1;
      start = 1'b0;
      if (len > 0) chk("in_ready_rise", in_ready, 1);
      got   = 0;
      guard = 0;
      while (got < len && guard < 2000) begin
         set_beat(dir, (got == 0) ? dn0 : dn1, (got == 0) ? dw0 : dw1);
         in_valid = ($urandom_range(99) < vprob);
         hs = in_valid && in_ready;
         if (hs) sum += beat_sum(neuron, weight);
         @(posedge clk); #1;
         guard++;
         if (hs) got++;
      end
      if (guard >= 2000) chk("beat_timeout", got, len);
      in_valid = 1'b0;
      sb_q.push_back(sat32(sum));
      if (len > 0) begin
         chk("drain_valid", out_valid, 0);
         chk("drain_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      chk("out_valid_lat", out_valid, 1);
      if (has_c) chk("out_data_const", out_data, c_exp);
      for (int k = 0; k < hold; k++) begin
         if (pulse && k == 0) begin
            start   = 1'b1;
            vec_len = 16'd5;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      out_ready = 1'b1;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 20) chk("out_timeout", out_valid, 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_busy", busy, 0);
      chk("post_valid", out_valid, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc_n;
      int guard;
      bit hs;
      rst = 1'b1; start = 1'b0; vec_len = '0; bias = '0;
      in_valid = 1'b0; neuron = '0; weight = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Abort a job after three accepted beats
      start = 1'b1; vec_len = 16'd8; bias = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      acc_n = 0; guard = 0;
      while (acc_n < 3 && guard < 50) begin
         set_beat(1'b0, 0, 0);
         hs = in_ready;
         @(posedge clk); #1;
         guard++;
         if (hs) acc_n++;
      end
      chk("midjob_beats", acc_n, 3);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;

      run_job(1, 0, 100, 0, 1'b1, 1, 1, 1, 1, 1'b1, 32'd32, 1'b0);
      run_job(2, 10, 100, 1, 1'b1, 2, 3, -1, 4, 1'b1, 32'd74, 1'b0);
      run_job(0, -5, 100, 3, 1'b0, 0, 0, 0, 0, 1'b1, 32'hFFFF_FFFB, 1'b1);
      run_job(3, 0, 100, 0, 1'b1, 32767, 32767, 32767, 32767, 1'b1,
              sat32(64'sd3 * 64'sd32 * 64'sd1073676289), 1'b0);
      run_job(1, 0, 100, 0, 1'b1, -32768, 32767, -32768, 32767, 1'b1,
              sat32(-64'sd34358689792), 1'b0);
      run_job(12, int'($urandom), 50, 5, 1'b0, 0, 0, 0, 0, 1'b0, 32'd0, 1'b1);
      for (int j = 0; j < 8; j++) begin
         run_job(int'($urandom_range(20, 1)), int'($urandom), 70, int'($urandom_range(3, 0)),
                 1'b0, 0, 0, 0, 0, 1'b0, 32'd0, 1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
